// File: rtl/inv_share_arbiter_if.sv
// Bundle between the requesters / reciprocal unit (master side) and the
// shared-reciprocal arbiter (slave side).
interface inv_share_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_dd;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       q_out;
  logic [N_REQ-1:0]        q_valid;
  logic                    q_err;
  logic                    busy;
  logic                    inv_start;
  logic [DATA_W-1:0]       inv_dd;
  logic [DATA_W-1:0]       inv_q;
  logic                    inv_done;

  modport master (
    output req, req_dd, inv_q, inv_done,
    input  gnt, q_out, q_valid, q_err, busy, inv_start, inv_dd
  );

  modport slave (
    input  req, req_dd, inv_q, inv_done,
    output gnt, q_out, q_valid, q_err, busy, inv_start, inv_dd
  );
endinterface

// File: rtl/inv_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle reciprocal unit among N_REQ
// requesters, with divide-by-zero bypass and a done-timeout guard.
module inv_share_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned INT_BITS  = 2,
  parameter int unsigned FRAC_BITS = 30,
  parameter int unsigned MAX_LAT   = 64
) (
  input logic clk,
  input logic rst,
  inv_share_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned TMR_W = $clog2(MAX_LAT);
  // Saturated result of the fixed-point format, returned on error paths.
  localparam logic [DATA_W-1:0] SAT_VAL = DATA_W'({(INT_BITS + FRAC_BITS){1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic                zflag_q, zflag_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DATA_W-1:0]   inv_dd_q, inv_dd_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    q_valid_q, q_valid_d;
  logic [DATA_W-1:0]   q_out_q, q_out_d;
  logic                q_err_q, q_err_d;
  logic                inv_start_q, inv_start_d;
  logic                busy_q, busy_d;

  logic [IDX_W-1:0]    win_c;
  logic                any_req_c;
  logic [DATA_W-1:0]   dd_win_c;
  logic [N_REQ-1:0]    req_rot;
  int unsigned         idx;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  // First requester after rr_q, wrapping modulo N_REQ.
  always_comb begin
    win_c     = '0;
    any_req_c = 1'b0;
    idx       = 0;
    req_rot   = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx     = (32'(rr_q) + off) % N_REQ;
      req_rot = bus.req >> idx;
      if (!any_req_c && req_rot[0]) begin
        any_req_c = 1'b1;
        win_c     = IDX_W'(idx);
      end
    end
  end

  assign dd_win_c = DATA_W'(bus.req_dd >> (32'(win_c) * DATA_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      rr_q        <= IDX_W'(N_REQ - 1);
      zflag_q     <= 1'b0;
      timer_q     <= '0;
      inv_dd_q    <= '0;
      gnt_q       <= '0;
      q_valid_q   <= '0;
      q_out_q     <= '0;
      q_err_q     <= 1'b0;
      inv_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      rr_q        <= rr_d;
      zflag_q     <= zflag_d;
      timer_q     <= timer_d;
      inv_dd_q    <= inv_dd_d;
      gnt_q       <= gnt_d;
      q_valid_q   <= q_valid_d;
      q_out_q     <= q_out_d;
      q_err_q     <= q_err_d;
      inv_start_q <= inv_start_d;
      busy_q      <= busy_d;
    end
  end

  // Pulsed outputs are computed on the transition into the state they belong to.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    rr_d        = rr_q;
    zflag_d     = zflag_q;
    timer_d     = timer_q;
    inv_dd_d    = inv_dd_q;
    gnt_d       = '0;
    q_valid_d   = '0;
    q_out_d     = '0;
    q_err_d     = 1'b0;
    inv_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          win_d       = win_c;
          inv_dd_d    = dd_win_c;
          zflag_d     = (dd_win_c == '0);
          gnt_d       = onehot(win_c);
          inv_start_d = (dd_win_c != '0);
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (zflag_q) begin
          q_valid_d = onehot(win_q);
          q_out_d   = SAT_VAL;
          q_err_d   = 1'b1;
          state_d   = S_RESP;
        end else begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.inv_done) begin
          q_valid_d = onehot(win_q);
          q_out_d   = bus.inv_q;
          state_d   = S_RESP;
        end else if (timer_q == TMR_W'(MAX_LAT - 1)) begin
          q_valid_d = onehot(win_q);
          q_out_d   = SAT_VAL;
          q_err_d   = 1'b1;
          state_d   = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        rr_d    = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign bus.gnt       = gnt_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.q_out     = q_out_q;
  assign bus.q_err     = q_err_q;
  assign bus.inv_start = inv_start_q;
  assign bus.inv_dd    = inv_dd_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_inv_share_arbiter.sv
// Directed bench for inv_share_arbiter; the reciprocal unit is played by
// hand-timed inv_done/inv_q stimulus.
module tb_inv_share_arbiter;
  localparam int unsigned N_REQ   = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAX_LAT = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  inv_share_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  inv_share_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .INT_BITS(2), .FRAC_BITS(30), .MAX_LAT(MAX_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_dd(input int i, input logic [DATA_W-1:0] v);
    bus.req_dd[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_gnt"},       64'(bus.gnt),       64'h0);
    check({tag, "_q_valid"},   64'(bus.q_valid),   64'h0);
    check({tag, "_q_out"},     64'(bus.q_out),     64'h0);
    check({tag, "_q_err"},     64'(bus.q_err),     64'h0);
    check({tag, "_inv_start"}, 64'(bus.inv_start), 64'h0);
    check({tag, "_inv_dd"},    64'(bus.inv_dd),    64'h0);
    check({tag, "_busy"},      64'(bus.busy),      64'h0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_dd   = '0;
    bus.inv_q    = '0;
    bus.inv_done = 1'b0;
    tick();
    check_cleared("reset");
    rst = 1'b0;
    tick();

    // Single operation, done 5 cycles after start.
    set_dd(0, 32'h4000_0000);
    bus.req = 4'b0001;
    tick();
    check("t1_gnt",       64'(bus.gnt),       64'h1);
    check("t1_inv_start", 64'(bus.inv_start), 64'h1);
    check("t1_inv_dd",    64'(bus.inv_dd),    64'h4000_0000);
    check("t1_busy",      64'(bus.busy),      64'h1);
    bus.req = 4'b0000;
    tick();
    check("t1_start_pulse", 64'(bus.inv_start), 64'h0);
    check("t1_gnt_pulse",   64'(bus.gnt),       64'h0);
    repeat (4) tick();
    check("t1_no_early_valid", 64'(bus.q_valid), 64'h0);
    bus.inv_done = 1'b1;
    bus.inv_q    = 32'h4000_0000;
    tick();
    bus.inv_done = 1'b0;
    check("t1_q_valid", 64'(bus.q_valid), 64'h1);
    check("t1_q_out",   64'(bus.q_out),   64'h4000_0000);
    check("t1_q_err",   64'(bus.q_err),   64'h0);
    tick();
    check("t1_valid_clr", 64'(bus.q_valid), 64'h0);
    check("t1_q_out_clr", 64'(bus.q_out),   64'h0);
    check("t1_idle",      64'(bus.busy),    64'h0);

    // Round robin from a fresh pointer with all four requesting.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_dd(i, 32'h1000_0000 * (i + 1));
    bus.req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      int w;
      w = n % 4;
      tick();
      check($sformatf("rr%0d_gnt", n),    64'(bus.gnt),             64'(4'b0001 << w));
      check($sformatf("rr%0d_onehot", n), 64'($countones(bus.gnt)), 64'h1);
      check($sformatf("rr%0d_inv_dd", n), 64'(bus.inv_dd),          64'(32'h1000_0000 * (w + 1)));
      bus.req[w] = 1'b0;
      tick();
      tick();
      bus.inv_done = 1'b1;
      bus.inv_q    = 32'h0100_0000 + 32'(n);
      tick();
      bus.inv_done = 1'b0;
      check($sformatf("rr%0d_q_valid", n), 64'(bus.q_valid), 64'(4'b0001 << w));
      check($sformatf("rr%0d_q_out", n),   64'(bus.q_out),   64'(32'h0100_0000 + 32'(n)));
      bus.req[w] = 1'b1;
      tick();
      check($sformatf("rr%0d_idle_gnt", n), 64'(bus.gnt), 64'h0);
    end
    bus.req = 4'b0000;
    tick();

    // Divide-by-zero bypass.
    set_dd(2, 32'h0);
    bus.req = 4'b0100;
    tick();
    check("zero_gnt",   64'(bus.gnt),       64'h4);
    check("zero_start", 64'(bus.inv_start), 64'h0);
    bus.req = 4'b0000;
    tick();
    check("zero_q_valid", 64'(bus.q_valid),   64'h4);
    check("zero_q_out",   64'(bus.q_out),     64'hFFFF_FFFF);
    check("zero_q_err",   64'(bus.q_err),     64'h1);
    check("zero_start2",  64'(bus.inv_start), 64'h0);
    tick();
    check("zero_idle", 64'(bus.busy), 64'h0);

    // Timeout with no inv_done, then a late done in IDLE.
    set_dd(3, 32'h2000_0000);
    bus.req = 4'b1000;
    tick();
    check("to_gnt",   64'(bus.gnt),       64'h8);
    check("to_start", 64'(bus.inv_start), 64'h1);
    bus.req = 4'b0000;
    repeat (8) tick();
    check("to_not_yet", 64'(bus.q_valid), 64'h0);
    tick();
    check("to_q_valid", 64'(bus.q_valid), 64'h8);
    check("to_q_err",   64'(bus.q_err),   64'h1);
    check("to_q_out",   64'(bus.q_out),   64'hFFFF_FFFF);
    tick();
    check("to_idle", 64'(bus.busy), 64'h0);
    bus.inv_done = 1'b1;
    bus.inv_q    = 32'h0000_1234;
    tick();
    bus.inv_done = 1'b0;
    check("late_q_valid", 64'(bus.q_valid), 64'h0);
    check("late_busy",    64'(bus.busy),    64'h0);
    check("late_gnt",     64'(bus.gnt),     64'h0);

    // Reset asserted 3 cycles into WAIT aborts the operation.
    set_dd(0, 32'h3000_0000);
    bus.req = 4'b0001;
    tick();
    check("mr_gnt", 64'(bus.gnt), 64'h1);
    bus.req = 4'b0000;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_cleared("mid_rst");
    bus.inv_done = 1'b1;
    tick();
    bus.inv_done = 1'b0;
    check("mr_no_valid", 64'(bus.q_valid), 64'h0);
    rst = 1'b0;
    tick();
    check("mr_no_valid2", 64'(bus.q_valid), 64'h0);
    check("mr_idle",      64'(bus.busy),    64'h0);
    set_dd(1, 32'h0800_0000);
    bus.req = 4'b0010;
    tick();
    check("mr_gnt_after", 64'(bus.gnt),    64'h2);
    check("mr_inv_dd",    64'(bus.inv_dd), 64'h0800_0000);
    bus.req = 4'b0000;
    tick();
    tick();
    bus.inv_done = 1'b1;
    bus.inv_q    = 32'h8000_0000;
    tick();
    bus.inv_done = 1'b0;
    check("mr_q_valid", 64'(bus.q_valid), 64'h2);
    tick();

    // Stray done in GRANT ignored; request queued during WAIT served next.
    set_dd(3, 32'h1555_5555);
    bus.req = 4'b1000;
    tick();
    check("st_gnt", 64'(bus.gnt), 64'h8);
    bus.inv_done = 1'b1;
    bus.inv_q    = 32'hDEAD_BEEF;
    bus.req      = 4'b0000;
    tick();
    bus.inv_done = 1'b0;
    check("st_ignored", 64'(bus.q_valid), 64'h0);
    check("st_busy",    64'(bus.busy),    64'h1);
    set_dd(1, 32'h0C00_0000);
    bus.req = 4'b0010;
    tick();
    check("st_wait_gnt",   64'(bus.gnt),     64'h0);
    check("st_wait_valid", 64'(bus.q_valid), 64'h0);
    bus.inv_done = 1'b1;
    bus.inv_q    = 32'h2AAA_AAAA;
    tick();
    bus.inv_done = 1'b0;
    check("st_q_valid", 64'(bus.q_valid), 64'h8);
    check("st_q_out",   64'(bus.q_out),   64'h2AAA_AAAA);
    check("st_q_err",   64'(bus.q_err),   64'h0);
    tick();
    check("st_idle_gnt", 64'(bus.gnt), 64'h0);
    tick();
    check("st_next_gnt", 64'(bus.gnt),    64'h2);
    check("st_next_dd",  64'(bus.inv_dd), 64'h0C00_0000);
    bus.req = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
